operand_stack: RTL and testbench
================================

Name: operand_stack

Overview:
- Parametrised, typed WebAssembly operand stack for the cpu core.
- Replaces the fixed single-result path behind the existing result/result_type/result_empty outputs.
- Each cycle it can pop up to 3 entries and optionally push one, covering binary ops (pop 2, push 1), unary ops (pop 1, push 1) and select (pop 3, push 1).
- It checks operand types and depth, and raises sticky traps.

Parameters:
DEPTH, 16, number of stack entries (power of two, >= 4)
WIDTH, 64, data bits per entry
TYPE_W, 2, type tag bits per entry (encodings i32/i64/f32/f64 from cpu.vh)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush of all entries (function return); does not clear trap
pop_n  in  2  number of entries popped this cycle (0..3)
push_en  in  1  push one entry after the pops
push_data  in  WIDTH  data to push
push_type  in  TYPE_W  type tag of pushed entry
check_en  in  1  enable type check of popped entries
check_type  in  TYPE_W  required type for every popped entry except the select condition
check_sel  in  1  when pop_n=3: entry 0 (top) must be i32; entries 1 and 2 must match each other
top0 / top0_type  out  WIDTH / TYPE_W  top entry (equals result / result_type at the cpu boundary)
top1 / top1_type  out  WIDTH / TYPE_W  second entry
top2 / top2_type  out  WIDTH / TYPE_W  third entry
count  out  $clog2(DEPTH)+1  current number of entries
empty  out  1  count==0
full  out  1  count==DEPTH
trap  out  3  trap code from cpu.vh; 0 = none

Behaviour:
- Reset (reset low, asynchronous):
  - count=0, empty=1, full=0, trap=0.
  - top0/1/2 and their types are 0.
  - Storage contents are don't-care.
- Outputs:
  - All outputs reflect state registered at the last rising clk edge.
  - top_k reads entry count-1-k; it reads 0 when k >= count.
- Operation is one cycle. At each edge, with trap==0 and clear==0:
  - Underflow: pop_n > count -> trap=TRAP_STACK_UNDERFLOW. No state change.
  - Overflow: count - pop_n + push_en > DEPTH -> trap=TRAP_STACK_OVERFLOW. No state change.
  - Type check, check_en=1, check_sel=0: any popped entry whose tag != check_type -> trap=TRAP_TYPE_MISMATCH. No state change.
  - Type check, check_en=1, check_sel=1, pop_n=3: top0_type != i32, or top1_type != top2_type -> TRAP_TYPE_MISMATCH.
  - Otherwise: count <= count - pop_n + push_en. If push_en, entry at new count-1 <= {push_type, push_data}.
- Error priority: underflow > overflow > type mismatch.
- Pushes exactly at full with pop_n>=1 are legal (pop-then-push, net <= 0).
- pop_n=0, push_en=0 is a no-op.
- Trap is sticky:
  - Once nonzero, every later operation, including clear, is ignored until reset.
  - Outputs hold their last values.
- clear=1 (trap==0): count <= 0, regardless of pop_n/push_en in the same cycle.
- Reset asserted mid-operation aborts the cycle. The first edge after reset release performs a normal operation.
- Data is not modified or interpreted; WIDTH is stored as given. i32 values are held zero-extended by the producer.

Decomposition:
- cpu.vh (shared):
  - Type codes i32/i64/f32/f64.
  - Trap codes: TRAP_NONE=0, TRAP_STACK_UNDERFLOW, TRAP_STACK_OVERFLOW, TRAP_TYPE_MISMATCH.
  - pop_n meanings as named constants.
- One natural sub-module: stack_ram, a DEPTH x (TYPE_W+WIDTH) register file.
  - One write port.
  - Three combinational read ports addressed count-1, count-2, count-3.
- Check/pointer logic stays in operand_stack.

Test Plan:
1. Binary op:
   - Stimulus: push i32 1, push i32 2, then pop_n=2 + push i32 3 with check_en, check_type=i32.
   - Required response: count=1, top0=3, top0_type=i32, empty=0, trap=0.
2. Select:
   - Stimulus: push i64 10, push i64 20, push i32 0, then pop_n=3, check_sel=1, push i64 20.
   - Required response: count=1, top0=20, top0_type=i64.
3. Underflow:
   - Stimulus: from reset, pop_n=1.
   - Required response: trap=TRAP_STACK_UNDERFLOW, count=0.
   - Follow-up: subsequent pushes ignored (count stays 0) until reset low; after reset trap=0.
4. Overflow / full:
   - Stimulus: push DEPTH=16 entries.
   - Required response: full=1, count=16.
   - Then pop_n=1 + push: legal, count=16, top0 = new value.
   - Then plain push: trap=TRAP_STACK_OVERFLOW, top0 unchanged.
5. Type mismatch:
   - Stimulus: push f32 then i32, pop_n=2, check_type=i32.
   - Required response: trap=TRAP_TYPE_MISMATCH, count=2, top0/top1 unchanged.
6. Clear and async reset:
   - Stimulus: push 3 entries, clear=1 with push_en=1 in the same cycle.
   - Required response: count=0, empty=1.
   - Then push 2 entries and pulse reset low between clock edges.
   - Required response: count=0 and trap=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/operand_stack_pkg.sv
// Shared definitions for the WebAssembly operand stack: value type tags,
// trap codes and the named meanings of the pop count.
package operand_stack_pkg;

    // Value type tags carried alongside every stack entry.
    typedef enum logic [1:0] {
        TY_I32 = 2'd0,
        TY_I64 = 2'd1,
        TY_F32 = 2'd2,
        TY_F64 = 2'd3
    } val_type_e;

    // Trap codes; TRAP_NONE means the stack is operating normally.
    typedef enum logic [2:0] {
        TRAP_NONE            = 3'd0,
        TRAP_STACK_UNDERFLOW = 3'd1,
        TRAP_STACK_OVERFLOW  = 3'd2,
        TRAP_TYPE_MISMATCH   = 3'd3
    } trap_e;

    // Number of entries consumed by an operation class.
    localparam logic [1:0] POP_NONE   = 2'd0;  // push / no-op
    localparam logic [1:0] POP_UNARY  = 2'd1;  // unary op
    localparam logic [1:0] POP_BINARY = 2'd2;  // binary op
    localparam logic [1:0] POP_SELECT = 2'd3;  // select (cond + two values)

endpackage

// File: rtl/operand_stack_ram.sv
// Operand stack storage: DEPTH x ENT_W register file.
// Ports:
//   clk_i             clock
//   we_i              write enable
//   waddr_i/wdata_i   write address / entry ({type, data})
//   raddrK_i          combinational read address K (K = 0..2)
//   rdataK_o          combinational read data K
// Contents are not reset; the stack pointer in the parent decides validity.
module operand_stack_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ENT_W = 66,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [ENT_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr0_i,
    input  logic [AW-1:0]    raddr1_i,
    input  logic [AW-1:0]    raddr2_i,
    output logic [ENT_W-1:0] rdata0_o,
    output logic [ENT_W-1:0] rdata1_o,
    output logic [ENT_W-1:0] rdata2_o
);

    logic [ENT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/operand_stack.sv
// Typed WebAssembly operand stack. Each cycle pops 0..3 entries and then
// optionally pushes one, checking depth and operand types; any violation
// raises a sticky trap that freezes the stack until reset.
// Ports:
//   clk, reset (async, active-low)
//   clear                       flush all entries (ignored once trapped)
//   pop_n, push_en              entries popped, then optional push
//   push_data, push_type        entry pushed
//   check_en, check_type        require every popped entry to have check_type
//   check_sel                   select form: top must be i32, next two must match
//   top0..2 / top0..2_type      top three entries (0 when absent)
//   count, empty, full          occupancy
//   trap                        trap code, 0 = none
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned TYPE_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [1:0]             pop_n,
    input  logic                   push_en,
    input  logic [WIDTH-1:0]       push_data,
    input  logic [TYPE_W-1:0]      push_type,
    input  logic                   check_en,
    input  logic [TYPE_W-1:0]      check_type,
    input  logic                   check_sel,
    output logic [WIDTH-1:0]       top0,
    output logic [TYPE_W-1:0]      top0_type,
    output logic [WIDTH-1:0]       top1,
    output logic [TYPE_W-1:0]      top1_type,
    output logic [WIDTH-1:0]       top2,
    output logic [TYPE_W-1:0]      top2_type,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic [2:0]             trap
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned NW = CW + 1;   // headroom for count + 1
    localparam int unsigned EW = TYPE_W + WIDTH;

    logic [CW-1:0] count_q, count_d;
    trap_e         trap_q, trap_d;

    logic          we;
    logic [AW-1:0] waddr;
    logic [EW-1:0] rd0, rd1, rd2;
    logic [EW-1:0] ent0, ent1, ent2;
    logic [NW-1:0] next_cnt;
    logic          type_bad;

    operand_stack_ram #(
        .DEPTH (DEPTH),
        .ENT_W (EW),
        .AW    (AW)
    ) u_ram (
        .clk_i    (clk),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  ({push_type, push_data}),
        .raddr0_i (AW'(count_q - CW'(1))),
        .raddr1_i (AW'(count_q - CW'(2))),
        .raddr2_i (AW'(count_q - CW'(3))),
        .rdata0_o (rd0),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Read ports wrap around when fewer than three entries exist; mask those.
    assign ent0 = (count_q > CW'(0)) ? rd0 : '0;
    assign ent1 = (count_q > CW'(1)) ? rd1 : '0;
    assign ent2 = (count_q > CW'(2)) ? rd2 : '0;

    assign top0      = ent0[WIDTH-1:0];
    assign top0_type = ent0[EW-1 -: TYPE_W];
    assign top1      = ent1[WIDTH-1:0];
    assign top1_type = ent1[EW-1 -: TYPE_W];
    assign top2      = ent2[WIDTH-1:0];
    assign top2_type = ent2[EW-1 -: TYPE_W];

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign trap  = trap_q;

    // Pop-then-push: the pushed entry lands where the last popped one was.
    assign next_cnt = NW'(count_q) - NW'(pop_n) + NW'(push_en);
    assign waddr    = AW'(count_q - CW'(pop_n));

    always_comb begin
        type_bad = 1'b0;
        if (check_en) begin
            if (check_sel && (pop_n == POP_SELECT)) begin
                type_bad = (top0_type != TYPE_W'(TY_I32)) || (top1_type != top2_type);
            end else begin
                if ((pop_n >= POP_UNARY)  && (top0_type != check_type)) type_bad = 1'b1;
                if ((pop_n >= POP_BINARY) && (top1_type != check_type)) type_bad = 1'b1;
                if ((pop_n == POP_SELECT) && (top2_type != check_type)) type_bad = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        trap_d  = trap_q;
        we      = 1'b0;
        if (trap_q == TRAP_NONE) begin
            if (clear) begin
                count_d = '0;
            end else if (CW'(pop_n) > count_q) begin
                trap_d = TRAP_STACK_UNDERFLOW;
            end else if (next_cnt > NW'(DEPTH)) begin
                trap_d = TRAP_STACK_OVERFLOW;
            end else if (type_bad) begin
                trap_d = TRAP_TYPE_MISMATCH;
            end else begin
                count_d = CW'(next_cnt);
                we      = push_en;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            count_q <= count_d;
            trap_q  <= trap_d;
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// Scoreboard bench for operand_stack: a queue-based stack model produces the
// expected view after every operation; a monitor compares it with the DUT.
module tb_operand_stack;
    import operand_stack_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned WIDTH  = 64;
    localparam int unsigned TYPE_W = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   clear = 1'b0;
    logic [1:0]             pop_n = '0;
    logic                   push_en = 1'b0;
    logic [WIDTH-1:0]       push_data = '0;
    logic [TYPE_W-1:0]      push_type = '0;
    logic                   check_en = 1'b0;
    logic [TYPE_W-1:0]      check_type = '0;
    logic                   check_sel = 1'b0;
    logic [WIDTH-1:0]       top0, top1, top2;
    logic [TYPE_W-1:0]      top0_type, top1_type, top2_type;
    logic [$clog2(DEPTH):0] count;
    logic                   empty, full;
    logic [2:0]             trap;

    operand_stack #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .TYPE_W (TYPE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .pop_n      (pop_n),
        .push_en    (push_en),
        .push_data  (push_data),
        .push_type  (push_type),
        .check_en   (check_en),
        .check_type (check_type),
        .check_sel  (check_sel),
        .top0       (top0),
        .top0_type  (top0_type),
        .top1       (top1),
        .top1_type  (top1_type),
        .top2       (top2),
        .top2_type  (top2_type),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned       cnt;
        logic [WIDTH-1:0]  d0, d1, d2;
        logic [TYPE_W-1:0] t0, t1, t2;
        logic [2:0]        trap;
    } exp_t;

    exp_t exp_q[$];
    logic [TYPE_W+WIDTH-1:0] stk[$];   // model stack, back = top
    logic [2:0] m_trap = 3'd0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic async_tick = 1'b0;

    function automatic logic [TYPE_W-1:0] ty_of(input logic [TYPE_W+WIDTH-1:0] e);
        return e[WIDTH +: TYPE_W];
    endfunction

    function automatic exp_t model_view();
        exp_t e;
        int unsigned n = stk.size();
        logic [TYPE_W+WIDTH-1:0] v[3];
        for (int unsigned k = 0; k < 3; k++) v[k] = (k < n) ? stk[n-1-k] : '0;
        e.cnt  = n;
        e.d0 = v[0][WIDTH-1:0]; e.t0 = ty_of(v[0]);
        e.d1 = v[1][WIDTH-1:0]; e.t1 = ty_of(v[1]);
        e.d2 = v[2][WIDTH-1:0]; e.t2 = ty_of(v[2]);
        e.trap = m_trap;
        return e;
    endfunction

    task automatic model_op(input int unsigned pn, input logic pe, input logic [WIDTH-1:0] pd,
                            input logic [TYPE_W-1:0] pt, input logic ce,
                            input logic [TYPE_W-1:0] ct, input logic cs, input logic clr);
        int unsigned n = stk.size();
        logic bad = 1'b0;
        if (m_trap != TRAP_NONE) return;
        if (clr) begin
            stk.delete();
            return;
        end
        if (pn > n) begin
            m_trap = TRAP_STACK_UNDERFLOW;
            return;
        end
        if (n - pn + int'(pe) > DEPTH) begin
            m_trap = TRAP_STACK_OVERFLOW;
            return;
        end
        if (ce) begin
            if (cs && pn == 3)
                bad = (ty_of(stk[n-1]) != TY_I32) || (ty_of(stk[n-2]) != ty_of(stk[n-3]));
            else
                for (int unsigned i = 0; i < pn; i++)
                    if (ty_of(stk[n-1-i]) != ct) bad = 1'b1;
        end
        if (bad) begin
            m_trap = TRAP_TYPE_MISMATCH;
            return;
        end
        repeat (pn) void'(stk.pop_back());
        if (pe) stk.push_back({pt, pd});
    endtask

    task automatic cmp(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares the oldest expectation after each edge or async event.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_tick);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("count",     WIDTH'(count),     WIDTH'(e.cnt));
                cmp("empty",     WIDTH'(empty),     WIDTH'(e.cnt == 0));
                cmp("full",      WIDTH'(full),      WIDTH'(e.cnt == DEPTH));
                cmp("trap",      WIDTH'(trap),      WIDTH'(e.trap));
                cmp("top0",      top0,              e.d0);
                cmp("top0_type", WIDTH'(top0_type), WIDTH'(e.t0));
                cmp("top1",      top1,              e.d1);
                cmp("top1_type", WIDTH'(top1_type), WIDTH'(e.t1));
                cmp("top2",      top2,              e.d2);
                cmp("top2_type", WIDTH'(top2_type), WIDTH'(e.t2));
            end
        end
    end

    task automatic step(input logic [1:0] pn, input logic pe, input logic [WIDTH-1:0] pd,
                        input logic [TYPE_W-1:0] pt, input logic ce,
                        input logic [TYPE_W-1:0] ct, input logic cs, input logic clr);
        @(negedge clk);
        pop_n = pn; push_en = pe; push_data = pd; push_type = pt;
        check_en = ce; check_type = ct; check_sel = cs; clear = clr;
        model_op(int'(pn), pe, pd, pt, ce, ct, cs, clr);
        exp_q.push_back(model_view());
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [TYPE_W-1:0] t);
        step(POP_NONE, 1'b1, d, t, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Pulse reset between edges and check its effect before the next edge.
    task automatic areset();
        @(negedge clk);
        pop_n = POP_NONE; push_en = 1'b0; check_en = 1'b0; check_sel = 1'b0; clear = 1'b0;
        #1 reset = 1'b0;
        stk.delete();
        m_trap = TRAP_NONE;
        exp_q.push_back(model_view());
        async_tick = ~async_tick;
        #2 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] pn;
        logic pe, ce, cs, clr;
        logic [TYPE_W-1:0] ct;
        int unsigned n;

        areset();

        // Binary op: 1 2 -> 3
        push(64'd1, TY_I32);
        push(64'd2, TY_I32);
        step(POP_BINARY, 1'b1, 64'd3, TY_I32, 1'b1, TY_I32, 1'b0, 1'b0);

        // Select
        areset();
        push(64'd10, TY_I64);
        push(64'd20, TY_I64);
        push(64'd0, TY_I32);
        step(POP_SELECT, 1'b1, 64'd20, TY_I64, 1'b1, TY_I64, 1'b1, 1'b0);

        // Underflow from empty, then sticky
        areset();
        step(POP_UNARY, 1'b0, '0, TY_I32, 1'b0, '0, 1'b0, 1'b0);
        push(64'd5, TY_I32);
        step(POP_NONE, 1'b0, '0, TY_I32, 1'b0, '0, 1'b0, 1'b1);
        areset();

        // Fill to DEPTH, legal pop+push at full, then overflow
        for (int unsigned i = 0; i < DEPTH; i++) push(64'(100 + i), TY_I64);
        step(POP_UNARY, 1'b1, 64'hDEAD_BEEF, TY_F64, 1'b0, '0, 1'b0, 1'b0);
        push(64'd999, TY_I32);

        // Type mismatch
        areset();
        push(64'h3F80_0000, TY_F32);
        push(64'd7, TY_I32);
        step(POP_BINARY, 1'b1, 64'd1, TY_I32, 1'b1, TY_I32, 1'b0, 1'b0);
        areset();

        // Clear wins over a same-cycle push; then async reset with entries
        push(64'd1, TY_I32);
        push(64'd2, TY_I64);
        push(64'd3, TY_F32);
        step(POP_NONE, 1'b1, 64'd4, TY_I32, 1'b0, '0, 1'b0, 1'b1);
        push(64'd5, TY_F64);
        push(64'd6, TY_I32);
        areset();

        // Randomised operations against the model
        for (int unsigned it = 0; it < 800; it++) begin
            if (m_trap != 3'd0 && $urandom_range(0, 2) == 0) begin
                areset();
            end else begin
                n   = stk.size();
                pn  = 2'($urandom_range(0, 3));
                if (int'(pn) > n && $urandom_range(0, 7) != 0) pn = 2'((n > 3) ? 3 : n);
                pe  = ($urandom_range(0, 9) < 6);
                ce  = 1'($urandom_range(0, 1));
                ct  = (n > 0 && $urandom_range(0, 9) < 8) ? ty_of(stk[n-1]) : TYPE_W'($urandom_range(0, 3));
                cs  = (pn == POP_SELECT) && ($urandom_range(0, 1) == 1);
                clr = ($urandom_range(0, 40) == 0);
                step(pn, pe, {$urandom, $urandom}, TYPE_W'($urandom_range(0, 3)), ce, ct, cs, clr);
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
